// File: rtl/tally_counter_param.sv
// Debounced up/down tally counter with saturating or wrapping bounds.
// Outputs the count as thermometer LEDs, as binary, and as registered status flags.
module tally_counter_param #(
  parameter int MAX  = 15,
  parameter int DEB  = 4,
  parameter int WRAP = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       TICK,
  input  logic                       BTN_UP,
  input  logic                       BTN_DN,
  input  logic                       CLR,
  output logic [MAX-1:0]             LED,
  output logic [$clog2(MAX+1)-1:0]   COUNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       OVF,
  output logic                       UNF
);

  localparam int BW = $clog2(MAX + 1);
  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [BW-1:0] MAX_C  = BW'(MAX);
  localparam logic [DW-1:0] DEB_TC = DW'(DEB - 1);

  // Bit 0 = up button, bit 1 = down button throughout.
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    db_q, db_d;
  logic [1:0]    db_dly_q, db_dly_d;
  logic [1:0]    ev_q, ev_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];

  logic [BW-1:0]  count_q, count_d;
  logic [MAX-1:0] led_q, led_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  always_comb begin
    sync1_d   = {BTN_DN, BTN_UP};
    sync2_d   = sync1_q;
    db_d      = db_q;
    deb_cnt_d = deb_cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (TICK) begin
        if (sync2_q[b] == db_q[b]) begin
          deb_cnt_d[b] = '0;
        end else if (deb_cnt_q[b] == DEB_TC) begin
          db_d[b]      = ~db_q[b];
          deb_cnt_d[b] = '0;
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
        end
      end
    end
    db_dly_d = db_q;
    // Press events fire one cycle after the accepted level rises; releases are silent.
    ev_d     = db_q & ~db_dly_q;
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (CLR) begin
      count_d = '0;
    end else if (ev_q[0] && !ev_q[1]) begin
      if (count_q == MAX_C) begin
        ovf_d = 1'b1;
        if (WRAP != 0) count_d = '0;
      end else begin
        count_d = count_q + BW'(1);
      end
    end else if (ev_q[1] && !ev_q[0]) begin
      if (count_q == '0) begin
        unf_d = 1'b1;
        if (WRAP != 0) count_d = MAX_C;
      end else begin
        count_d = count_q - BW'(1);
      end
    end
    // Status outputs are derived from the next count so they change on the same edge.
    for (int i = 0; i < MAX; i++) begin
      led_d[i] = (count_d > BW'(i));
    end
    full_d  = (count_d == MAX_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      db_dly_q     <= '0;
      ev_q         <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      count_q      <= '0;
      led_q        <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      db_dly_q     <= db_dly_d;
      ev_q         <= ev_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      count_q      <= count_d;
      led_q        <= led_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign LED   = led_q;
  assign COUNT = count_q;
  assign FULL  = full_q;
  assign EMPTY = empty_q;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule

// File: tb/tb_tally_counter_param.sv
// Bench for tally_counter_param: two instances (saturating MAX=15, wrapping MAX=9)
// share the stimulus; table rows, corner sequences and random operations are checked.
module tb_tally_counter_param;

  logic clk = 1'b0;
  logic rst, tick, btn_up, btn_dn, clr;

  logic [14:0] led_a;
  logic [3:0]  count_a;
  logic        full_a, empty_a, ovf_a, unf_a;
  logic [8:0]  led_b;
  logic [3:0]  count_b;
  logic        full_b, empty_b, ovf_b, unf_b;

  tally_counter_param #(.MAX(15), .DEB(2), .WRAP(0)) dut_a (
    .CLK(clk), .RST(rst), .TICK(tick), .BTN_UP(btn_up), .BTN_DN(btn_dn), .CLR(clr),
    .LED(led_a), .COUNT(count_a), .FULL(full_a), .EMPTY(empty_a), .OVF(ovf_a), .UNF(unf_a)
  );

  tally_counter_param #(.MAX(9), .DEB(2), .WRAP(1)) dut_b (
    .CLK(clk), .RST(rst), .TICK(tick), .BTN_UP(btn_up), .BTN_DN(btn_dn), .CLR(clr),
    .LED(led_b), .COUNT(count_b), .FULL(full_b), .EMPTY(empty_b), .OVF(ovf_b), .UNF(unf_b)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_UP, OP_DN, OP_BOTH, OP_CLR, OP_RST} op_e;
  typedef struct {
    op_e op;
    int  ea, eb;
    int  oa, ua, ob, ub;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int tick_period = 1;
  int phase = 0;

  int n_ovf_a = 0, n_unf_a = 0, n_ovf_b = 0, n_unf_b = 0;
  int s_ovf_a, s_unf_a, s_ovf_b, s_unf_b;
  int wide_err = 0, range_err = 0;
  logic p_ovf_a = 0, p_unf_a = 0, p_ovf_b = 0, p_unf_b = 0;

  always @(negedge clk) begin
    if (ovf_a) n_ovf_a <= n_ovf_a + 1;
    if (unf_a) n_unf_a <= n_unf_a + 1;
    if (ovf_b) n_ovf_b <= n_ovf_b + 1;
    if (unf_b) n_unf_b <= n_unf_b + 1;
    if ((ovf_a && p_ovf_a) || (unf_a && p_unf_a) || (ovf_b && p_ovf_b) || (unf_b && p_unf_b))
      wide_err <= wide_err + 1;
    if (count_b > 4'd9) range_err <= range_err + 1;
    p_ovf_a <= ovf_a; p_unf_a <= unf_a; p_ovf_b <= ovf_b; p_unf_b <= unf_b;
  end

  task automatic step();
    @(negedge clk);
    phase++;
    tick = ((phase % tick_period) == 0);
  endtask

  task automatic cmp(string what, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  function automatic int therm(int c);
    return (1 << c) - 1;
  endfunction

  task automatic snap();
    s_ovf_a = n_ovf_a; s_unf_a = n_unf_a; s_ovf_b = n_ovf_b; s_unf_b = n_unf_b;
  endtask

  task automatic check(string nm, int ea, int eb, int oa, int ua, int ob, int ub);
    cmp({nm, " count_a"}, int'(count_a), ea);
    cmp({nm, " led_a"},   int'(led_a),   therm(ea));
    cmp({nm, " full_a"},  int'(full_a),  int'(ea == 15));
    cmp({nm, " empty_a"}, int'(empty_a), int'(ea == 0));
    cmp({nm, " ovf_a"},   n_ovf_a - s_ovf_a, oa);
    cmp({nm, " unf_a"},   n_unf_a - s_unf_a, ua);
    cmp({nm, " count_b"}, int'(count_b), eb);
    cmp({nm, " led_b"},   int'(led_b),   therm(eb));
    cmp({nm, " full_b"},  int'(full_b),  int'(eb == 9));
    cmp({nm, " empty_b"}, int'(empty_b), int'(eb == 0));
    cmp({nm, " ovf_b"},   n_ovf_b - s_ovf_b, ob);
    cmp({nm, " unf_b"},   n_unf_b - s_unf_b, ub);
  endtask

  task automatic apply_op(op_e op);
    int hold;
    hold = 10 + 4 * tick_period;
    case (op)
      OP_UP:   begin btn_up = 1; repeat (hold) step(); btn_up = 0; repeat (hold) step(); end
      OP_DN:   begin btn_dn = 1; repeat (hold) step(); btn_dn = 0; repeat (hold) step(); end
      OP_BOTH: begin
        btn_up = 1; btn_dn = 1; repeat (hold) step();
        btn_up = 0; btn_dn = 0; repeat (hold) step();
      end
      OP_CLR:  begin clr = 1; step(); clr = 0; repeat (4) step(); end
      default: begin rst = 1; repeat (2) step(); rst = 0; repeat (4) step(); end
    endcase
  endtask

  function automatic int model_next(int c, op_e op, int mx, bit wrap);
    case (op)
      OP_UP:   return (c == mx) ? (wrap ? 0 : mx) : c + 1;
      OP_DN:   return (c == 0) ? (wrap ? mx : 0) : c - 1;
      OP_BOTH: return c;
      default: return 0;
    endcase
  endfunction

  vec_t tbl [12];
  int   waited;
  int   ma, mb;

  initial begin
    tbl[0]  = '{OP_RST,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{OP_UP,   1, 1, 0, 0, 0, 0};
    tbl[2]  = '{OP_UP,   2, 2, 0, 0, 0, 0};
    tbl[3]  = '{OP_UP,   3, 3, 0, 0, 0, 0};
    tbl[4]  = '{OP_DN,   2, 2, 0, 0, 0, 0};
    tbl[5]  = '{OP_BOTH, 2, 2, 0, 0, 0, 0};
    tbl[6]  = '{OP_CLR,  0, 0, 0, 0, 0, 0};
    tbl[7]  = '{OP_DN,   0, 9, 0, 1, 0, 1};
    tbl[8]  = '{OP_UP,   1, 0, 0, 0, 1, 0};
    tbl[9]  = '{OP_DN,   0, 9, 0, 0, 0, 1};
    tbl[10] = '{OP_DN,   0, 8, 0, 1, 0, 0};
    tbl[11] = '{OP_CLR,  0, 0, 0, 0, 0, 0};

    rst = 1; tick = 1; btn_up = 0; btn_dn = 0; clr = 0;
    repeat (3) step();
    snap();
    check("reset", 0, 0, 0, 0, 0, 0);
    rst = 0;
    step();

    for (int i = 0; i < 12; i++) begin
      snap();
      apply_op(tbl[i].op);
      check($sformatf("row%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].oa, tbl[i].ua, tbl[i].ob, tbl[i].ub);
    end

    // 16 presses: A saturates with one OVF, B wraps past 9 once.
    apply_op(OP_RST);
    snap();
    for (int i = 1; i <= 16; i++) begin
      apply_op(OP_UP);
      cmp($sformatf("up%0d count_a", i), int'(count_a), (i > 15) ? 15 : i);
      cmp($sformatf("up%0d count_b", i), int'(count_b), i % 10);
    end
    check("ups16", 15, 6, 1, 0, 1, 0);

    apply_op(OP_RST);
    snap();
    apply_op(OP_DN);
    check("dn_at_0", 0, 9, 0, 1, 0, 1);

    // Bounce: alternating samples never reach two in a row.
    apply_op(OP_RST);
    snap();
    btn_up = 1; step(); btn_up = 0; step(); btn_up = 1; step(); btn_up = 0; step();
    cmp("bounce_quiet count_a", int'(count_a), 0);
    btn_up = 1;
    waited = 0;
    while (count_a == 4'd0 && waited < 30) begin
      step();
      waited++;
    end
    cmp("bounce_latency", waited, 6);
    repeat (10) step();
    btn_up = 0;
    repeat (20) step();
    check("bounce_end", 1, 1, 0, 0, 0, 0);

    // Simultaneous press at 5.
    apply_op(OP_RST);
    repeat (5) apply_op(OP_UP);
    snap();
    apply_op(OP_BOTH);
    check("both_at5", 5, 5, 0, 0, 0, 0);

    // CLR overlapping the up event at 7.
    repeat (2) apply_op(OP_UP);
    snap();
    btn_up = 1;
    repeat (2) step();
    clr = 1;
    repeat (4) step();
    clr = 0;
    repeat (10) step();
    btn_up = 0;
    repeat (20) step();
    check("clr_vs_up", 0, 0, 0, 0, 0, 0);

    // Reset with one of two debounce samples already taken.
    apply_op(OP_RST);
    repeat (2) apply_op(OP_UP);
    snap();
    btn_up = 1;
    repeat (3) step();
    rst = 1;
    step();
    check("in_rst", 0, 0, 0, 0, 0, 0);
    cmp("in_rst ovf_a", int'(ovf_a), 0);
    cmp("in_rst unf_a", int'(unf_a), 0);
    step();
    rst = 0;
    repeat (5) step();
    cmp("rst_restart early count_a", int'(count_a), 0);
    step();
    cmp("rst_restart count_a", int'(count_a), 1);
    repeat (10) step();
    btn_up = 0;
    repeat (20) step();

    // Random operations with varying TICK rate.
    apply_op(OP_RST);
    ma = 0; mb = 0;
    for (int k = 0; k < 40; k++) begin
      op_e op;
      int  r, oa, ua, ob, ub;
      tick_period = $urandom_range(1, 3);
      r = $urandom_range(0, 9);
      op = (r < 4) ? OP_UP : (r < 7) ? OP_DN : (r == 7) ? OP_BOTH : (r == 8) ? OP_CLR : OP_RST;
      oa = int'(op == OP_UP && ma == 15);
      ua = int'(op == OP_DN && ma == 0);
      ob = int'(op == OP_UP && mb == 9);
      ub = int'(op == OP_DN && mb == 0);
      ma = model_next(ma, op, 15, 1'b0);
      mb = model_next(mb, op, 9, 1'b1);
      snap();
      apply_op(op);
      check($sformatf("rnd%0d op%0d", k, int'(op)), ma, mb, oa, ua, ob, ub);
    end

    step();
    cmp("pulse_width", wide_err, 0);
    cmp("b_range", range_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tally_counter_param.md
Name: tally_counter_param

Overview:
Parametrised successor to the lab button-driven tally counter. Debounces two push-buttons (up/down) and keeps a bounded count. Presents the count both as a thermometer ("stone-age" tally) LED bus and as binary for the seven-segment path. Sits between the board buttons and the LED/sseg drivers. Runs on the fast board clock and uses a TICK enable from the clock divider for debouncing, instead of being clocked by a divided clock.

Parameters:
MAX, 15, largest count value and number of tally LEDs; MAX >= 1.
DEB, 4, consecutive TICK samples that must disagree with the accepted level before it changes; DEB >= 1.
WRAP, 0, 0 = saturate at the bounds, 1 = wrap modulo MAX+1.
BW (localparam), $clog2(MAX+1), binary count width (4 for MAX=15).

Ports:
CLK  in  1  system clock; all state is updated on the rising edge.
RST  in  1  synchronous, active-high reset.
TICK  in  1  single-CLK-cycle sample enable from the clock divider.
BTN_UP  in  1  raw up button, asynchronous to CLK.
BTN_DN  in  1  raw down button, asynchronous to CLK.
CLR  in  1  synchronous clear, already clean (no debounce).
LED  out  MAX  thermometer output: LED[i] = 1 iff i < COUNT.
COUNT  out  BW  binary count, 0..MAX.
FULL  out  1  COUNT == MAX.
EMPTY  out  1  COUNT == 0.
OVF  out  1  one-cycle pulse on an up event at MAX.
UNF  out  1  one-cycle pulse on a down event at 0.

Behaviour:
- Reset (RST=1 at a CLK edge): synchronisers, debounced levels, debounce counters and COUNT all go to 0. LED=0, FULL=0, EMPTY=1, OVF=0, UNF=0. RST overrides all other inputs, including a press in flight.
- Synchronisation: each button passes through a 2-flop synchroniser clocked every CLK, not gated by TICK.
- Debounce, per button:
  - Registers: accepted level db and a counter.
  - On a TICK cycle where the synchronised value equals db, the counter clears.
  - On a TICK cycle where it differs, the counter increments. When DEB differing samples have been seen, db takes the new value and the counter clears.
  - Non-TICK cycles hold all debounce state.
  - A sample that returns to db before DEB is reached discards the partial count.
- Events: up_ev / dn_ev are one-CLK pulses on the 0->1 transition of the respective db. A release generates no event; a held button produces exactly one event.
- Count update, in priority order, on the CLK edge after the event pulse:
  1. CLR=1: COUNT <= 0; events that cycle are ignored; no OVF/UNF.
  2. up_ev and dn_ev in the same cycle: no change, no pulses.
  3. up_ev:
     - COUNT < MAX: COUNT+1.
     - COUNT = MAX: OVF=1, and COUNT holds (WRAP=0) or goes to 0 (WRAP=1).
  4. dn_ev:
     - COUNT > 0: COUNT-1.
     - COUNT = 0: UNF=1, and COUNT holds (WRAP=0) or goes to MAX (WRAP=1).
- OVF/UNF are registered and high for exactly one cycle per triggering event.
- LED, FULL and EMPTY are registered and update on the same edge as COUNT (zero extra latency relative to COUNT).
- Latency: button stable high at the pins → sync (2 cycles) → DEB TICK samples → db rises → up_ev (1 cycle) → COUNT changes (1 cycle).
- Arithmetic: all in BW bits, with explicit compares against MAX. Non-power-of-two MAX must wrap at MAX, not at 2^BW-1.

Test Plan:
1. MAX=15, DEB=2, TICK tied high, WRAP=0. RST, then pulse BTN_UP high for 10 cycles, three times. → COUNT=3, LED=15'h0007, EMPTY=0, FULL=0; exactly one increment per press.
2. Bounce: BTN_UP toggles 1,0,1,0 on successive TICKs, then holds 1 (DEB=2). → no increment during the toggling; exactly one increment after 2 stable samples; COUNT goes 0→1 only.
3. WRAP=0: 16 up presses from 0. → COUNT=15, LED=15'h7FFF, FULL=1; the 16th press gives OVF=1 for one cycle with COUNT still 15. Then one down press from 0 after RST gives UNF=1 with COUNT=0.
4. WRAP=1, MAX=9 (BW=4): 10 up presses. → COUNT sequence 1..9 then 0, with OVF on the 10th. A down press at 0 gives COUNT=9 and UNF=1; COUNT never shows 10–15.
5. Simultaneous: with COUNT=5, BTN_UP and BTN_DN rise on the same cycle. → no change, no pulses. CLR asserted in the same cycle as an up event at COUNT=7 gives COUNT=0, OVF=0.
6. Reset mid-press: RST asserted while BTN_UP has been stable for only 1 of DEB=2 samples. → after RST releases with the button still held, a full DEB stable samples are needed before COUNT=1; every output shows its reset value during RST.
